// File: rtl/alu_issue_ctrl_pkg.sv
// Shared types for the ALU issue controller.
//   insn_class_t : instruction class field insn[15:14]
//   alu_op_t     : ALU OP_Code values (passed to the ALU unmodified)
//   nzcv_t       : flag word layout, [3]N [2]Z [1]C [0]V
//   state_t      : issue FSM states
//   insn_t       : 16-bit instruction word layout
package alu_issue_ctrl_pkg;

  typedef enum logic [1:0] {
    CLS_ALU_RR = 2'b00,
    CLS_ALU_RI = 2'b01,
    CLS_LDI    = 2'b10,
    CLS_CMP    = 2'b11
  } insn_class_t;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_XOR  = 3'b100,
    OP_SHL  = 3'b101,
    OP_SHR  = 3'b110,
    OP_PASS = 3'b111
  } alu_op_t;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } nzcv_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_WB   = 2'b10
  } state_t;

  // rs shares bits [1:0] with the immediate field.
  typedef struct packed {
    insn_class_t cls;
    alu_op_t     op;
    logic [1:0]  rd;
    logic        cond;
    logic [7:0]  imm;
  } insn_t;

  function automatic logic [1:0] insn_rs(input insn_t i);
    return i.imm[1:0];
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Instruction handshake plus ALU operand/result bus.
//   master : the issue controller (accepts insns, drives ALU operands)
//   slave  : the environment (fetch source and combinational ALU)
//   insn_valid/insn_ready/insn : instruction valid/ready handshake
//   alu_a/alu_b/alu_op         : registered ALU operands and OP_Code
//   alu_result/alu_nzcv        : combinational ALU result and flags
interface alu_issue_if;
  logic        insn_valid;
  logic        insn_ready;
  logic [15:0] insn;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [2:0]  alu_op;
  logic [7:0]  alu_result;
  logic [3:0]  alu_nzcv;

  modport master (
    input  insn_valid, insn, alu_result, alu_nzcv,
    output insn_ready, alu_a, alu_b, alu_op
  );

  modport slave (
    output insn_valid, insn, alu_result, alu_nzcv,
    input  insn_ready, alu_a, alu_b, alu_op
  );
endinterface

// File: rtl/alu_issue_ctrl_regfile.sv
// regfile_4x8: small register file for the issue controller.
//   clk, rst          : clock, synchronous active-high clear of all entries
//   we/waddr/wdata    : single write port
//   raddr_a/rdata_a   : async read port A
//   raddr_b/rdata_b   : async read port B
//   dbg_sel/dbg_data  : async debug read port
module regfile_4x8 #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned NREGS  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [$clog2(NREGS)-1:0] waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [$clog2(NREGS)-1:0] raddr_a,
  output logic [DATA_W-1:0]        rdata_a,
  input  logic [$clog2(NREGS)-1:0] raddr_b,
  output logic [DATA_W-1:0]        rdata_b,
  input  logic [$clog2(NREGS)-1:0] dbg_sel,
  output logic [DATA_W-1:0]        dbg_data
);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];

  always_comb begin
    regs_d = regs_q;
    if (we) begin
      regs_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  assign rdata_a  = regs_q[raddr_a];
  assign rdata_b  = regs_q[raddr_b];
  assign dbg_data = regs_q[dbg_sel];

endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: initiator side of the ALU interface. Accepts one 16-bit
// instruction per three cycles (IDLE -> EXEC -> WB), reads operands from a
// 4x8 register file, drives registered ALU operands, and writes back the
// ALU result / NZCV flags in WB.
//   clk, rst  : rising-edge clock, synchronous active-high reset
//   bus       : alu_issue_if.master (insn handshake + ALU operand/result bus)
//   flags     : architectural NZCV register
//   wb_data   : last value written to a register (held)
//   done      : one-cycle pulse in WB of each retired instruction
//   dbg_sel   : debug register select
//   dbg_data  : combinational read of reg[dbg_sel]
// Build option: ALU_COND_EXEC_EN makes insn[8]=1 instructions conditional on
// Z==0 (sampled in EXEC); when undefined insn[8] is ignored.
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned NREGS  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  alu_issue_if.master              bus,
  output logic [3:0]               flags,
  output logic [DATA_W-1:0]        wb_data,
  output logic                     done,
  input  logic [$clog2(NREGS)-1:0] dbg_sel,
  output logic [DATA_W-1:0]        dbg_data
);

  state_t            state_q, state_d;
  insn_t             insn_q, insn_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  alu_op_t           alu_op_q, alu_op_d;
  nzcv_t             flags_q, flags_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;

  logic              rf_we;
  logic [DATA_W-1:0] rf_wdata;
  logic [DATA_W-1:0] rd_val;
  logic [DATA_W-1:0] rs_val;
  logic              skip;

`ifdef ALU_COND_EXEC_EN
  logic skip_q, skip_d;
  assign skip = skip_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      skip_q <= 1'b0;
    end else begin
      skip_q <= skip_d;
    end
  end
`else
  logic unused_rsvd;
  assign skip        = 1'b0;
  assign unused_rsvd = insn_q.cond;
`endif

  regfile_4x8 #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS)
  ) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .we       (rf_we),
    .waddr    (insn_q.rd),
    .wdata    (rf_wdata),
    .raddr_a  (insn_q.rd),
    .rdata_a  (rd_val),
    .raddr_b  (insn_rs(insn_q)),
    .rdata_b  (rs_val),
    .dbg_sel  (dbg_sel),
    .dbg_data (dbg_data)
  );

  always_comb begin
    state_d   = state_q;
    insn_d    = insn_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    alu_op_d  = alu_op_q;
    flags_d   = flags_q;
    wb_data_d = wb_data_q;
    rf_we     = 1'b0;
    rf_wdata  = bus.alu_result;
`ifdef ALU_COND_EXEC_EN
    skip_d    = skip_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (bus.insn_valid) begin
          insn_d  = insn_t'(bus.insn);
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        // LDI leaves the ALU operand registers untouched.
        if (insn_q.cls != CLS_LDI) begin
          alu_a_d  = rd_val;
          alu_b_d  = (insn_q.cls == CLS_ALU_RI) ? insn_q.imm : rs_val;
          alu_op_d = insn_q.op;
        end
`ifdef ALU_COND_EXEC_EN
        skip_d = insn_q.cond & flags_q.z;
`endif
        state_d = ST_WB;
      end
      ST_WB: begin
        if (!skip) begin
          unique case (insn_q.cls)
            CLS_ALU_RR, CLS_ALU_RI: begin
              rf_we     = 1'b1;
              rf_wdata  = bus.alu_result;
              wb_data_d = bus.alu_result;
              flags_d   = nzcv_t'(bus.alu_nzcv);
            end
            CLS_LDI: begin
              rf_we     = 1'b1;
              rf_wdata  = insn_q.imm;
              wb_data_d = insn_q.imm;
            end
            CLS_CMP: begin
              flags_d = nzcv_t'(bus.alu_nzcv);
            end
            default: ;
          endcase
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      insn_q    <= '0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_op_q  <= OP_ADD;
      flags_q   <= '0;
      wb_data_q <= '0;
    end else begin
      state_q   <= state_d;
      insn_q    <= insn_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_op_q  <= alu_op_d;
      flags_q   <= flags_d;
      wb_data_q <= wb_data_d;
    end
  end

  assign bus.insn_ready = (state_q == ST_IDLE);
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.alu_op     = alu_op_q;
  assign flags          = flags_q;
  assign wb_data        = wb_data_q;
  assign done           = (state_q == ST_WB);

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl paired with a small combinational ALU. A
// transaction-level model tracks registers, flags, wb_data and the
// accept-to-retire timeline; every cycle the DUT outputs are compared with it,
// and directed sequences pin the model with literal values.
module tb_alu_issue_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] flags;
  logic [7:0] wb_data;
  logic       done;
  logic [1:0] dbg_sel;
  logic [7:0] dbg_data;

  alu_issue_if bus();

  alu_issue_ctrl #(.DATA_W(8), .NREGS(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .flags    (flags),
    .wb_data  (wb_data),
    .done     (done),
    .dbg_sel  (dbg_sel),
    .dbg_data (dbg_data)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // ALU: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 shl, 110 shr, 111 pass B
  function automatic logic [11:0] alu_fn(input logic [2:0] op, input logic [7:0] a,
                                         input logic [7:0] b);
    logic [8:0] s;
    logic [7:0] r;
    logic       c;
    logic       v;
    s = '0; r = '0; c = 1'b0; v = 1'b0;
    case (op)
      3'd0: begin
        s = {1'b0, a} + {1'b0, b}; r = s[7:0]; c = s[8];
        v = (a[7] == b[7]) && (r[7] != a[7]);
      end
      3'd1: begin
        s = {1'b0, a} + {1'b0, ~b} + 9'd1; r = s[7:0]; c = s[8];
        v = (a[7] != b[7]) && (r[7] != a[7]);
      end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: begin r = {a[6:0], 1'b0}; c = a[7]; end
      3'd6: begin r = {1'b0, a[7:1]}; c = a[0]; end
      default: r = b;
    endcase
    return {r, r[7], (r == 8'h00), c, v};
  endfunction

  always_comb {bus.alu_result, bus.alu_nzcv} = alu_fn(bus.alu_op, bus.alu_a, bus.alu_b);

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]  m_regs [4];
  logic [3:0]  m_flags = '0;
  logic [7:0]  m_wb = '0, m_a = '0, m_b = '0;
  logic [2:0]  m_op = '0;
  logic [15:0] m_insn = '0;
  bit          m_busy = 0, m_skip = 0, m_init = 0;
  int          m_age = 0;
  int unsigned m_acc = 0;
  longint      cyc = 0, m_acc_cyc = 0;

  logic [1:0]  mc_cls, mc_rd, mc_rs;
  logic [7:0]  mc_imm, mc_opa, mc_opb;
  logic [11:0] mc_res;

  // An accepted instruction spends one cycle in operand fetch and retires on
  // the following edge; the model applies its effects at that retire edge.
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      for (int i = 0; i < 4; i++) m_regs[i] = '0;
      m_flags = '0; m_wb = '0; m_a = '0; m_b = '0; m_op = '0;
      m_busy = 0; m_age = 0; m_skip = 0; m_init = 1;
    end else if (m_busy) begin
      mc_cls = m_insn[15:14]; mc_rd = m_insn[10:9]; mc_rs = m_insn[1:0]; mc_imm = m_insn[7:0];
      mc_opa = m_regs[mc_rd];
      mc_opb = (mc_cls == 2'b01) ? mc_imm : m_regs[mc_rs];
      mc_res = alu_fn(m_insn[13:11], mc_opa, mc_opb);
      if (m_age == 0) begin
        m_age = 1;
        if (mc_cls != 2'b10) begin m_a = mc_opa; m_b = mc_opb; m_op = m_insn[13:11]; end
`ifdef ALU_COND_EXEC_EN
        m_skip = m_insn[8] && m_flags[2];
`else
        m_skip = 0;
`endif
      end else begin
        if (!m_skip) begin
          case (mc_cls)
            2'b00, 2'b01: begin
              m_regs[mc_rd] = mc_res[11:4]; m_wb = mc_res[11:4]; m_flags = mc_res[3:0];
            end
            2'b10: begin m_regs[mc_rd] = mc_imm; m_wb = mc_imm; end
            default: m_flags = mc_res[3:0];
          endcase
        end
        m_busy = 0;
      end
    end else if (bus.insn_valid) begin
      m_insn = bus.insn; m_busy = 1; m_age = 0; m_acc++; m_acc_cyc = cyc;
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      chk("insn_ready", {15'd0, bus.insn_ready}, {15'd0, !m_busy});
      chk("done", {15'd0, done}, {15'd0, (m_busy && m_age == 1)});
      chk("flags", {12'd0, flags}, {12'd0, m_flags});
      chk("wb_data", {8'd0, wb_data}, {8'd0, m_wb});
      chk("dbg_data", {8'd0, dbg_data}, {8'd0, m_regs[dbg_sel]});
      chk("alu_a", {8'd0, bus.alu_a}, {8'd0, m_a});
      chk("alu_b", {8'd0, bus.alu_b}, {8'd0, m_b});
      chk("alu_op", {13'd0, bus.alu_op}, {13'd0, m_op});
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [15:0] mk(input logic [1:0] cls, input logic [2:0] op,
                                     input logic [1:0] rd, input logic c, input logic [7:0] imm);
    return {cls, op, rd, c, imm};
  endfunction

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic issue(input logic [15:0] w);
    int unsigned start;
    int n;
    start = m_acc; n = 0;
    bus.insn_valid = 1'b1; bus.insn = w;
    while (m_acc == start && n < 20) begin
      dbg_sel = 2'($urandom);
      step(); n++;
    end
    if (m_acc == start) chk("accept_timeout", 16'd0, 16'd1);
  endtask

  task automatic drop();
    bus.insn_valid = 1'b0; bus.insn = 16'($urandom);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (m_busy && n < 10) begin step(); n++; end
    if (m_busy) chk("idle_timeout", 16'd0, 16'd1);
  endtask

  task automatic peek(input logic [1:0] r, input logic [7:0] exp, input string nm);
    dbg_sel = r;
    @(negedge clk);
    chk(nm, {8'd0, dbg_data}, {8'd0, exp});
    step();
  endtask

  task automatic peek_flags(input logic [3:0] exp, input string nm);
    @(negedge clk);
    chk(nm, {12'd0, flags}, {12'd0, exp});
    step();
  endtask

  longint prev_cyc;

  initial begin
    rst = 1'b1; bus.insn_valid = 1'b0; bus.insn = '0; dbg_sel = '0;
    repeat (3) step();
    rst = 1'b0;
    step();

    // Reset held two cycles while an LDI sits in EXEC: it must be discarded.
    issue(mk(2'b10, 3'd0, 2'd1, 1'b0, 8'h55));
    drop();
    rst = 1'b1;
    @(negedge clk); chk("rst_no_done", {15'd0, done}, 16'd0);
    step(); step();
    rst = 1'b0;
    @(negedge clk); chk("rst_ready", {15'd0, bus.insn_ready}, 16'd1);
    step();
    peek_flags(4'b0000, "rst_flags");
    for (int i = 0; i < 4; i++) peek(2'(i), 8'h00, "rst_reg");

    // LDI r0,E4; LDI r1,A2; ADD rr r0,r1
    issue(mk(2'b10, 3'd0, 2'd0, 1'b0, 8'hE4));
    issue(mk(2'b10, 3'd0, 2'd1, 1'b0, 8'hA2));
    issue(mk(2'b00, 3'd0, 2'd0, 1'b0, 8'h01));
    drop(); wait_idle();
    peek(2'd0, 8'h86, "add_r0");
    peek(2'd1, 8'hA2, "add_r1");
    peek_flags(4'b1010, "add_flags");

    // LDI r2,0A; SUB ri r2,0A; CMP r2,r2
    issue(mk(2'b10, 3'd0, 2'd2, 1'b0, 8'h0A));
    issue(mk(2'b01, 3'd1, 2'd2, 1'b0, 8'h0A));
    drop(); wait_idle();
    peek(2'd2, 8'h00, "subi_r2");
    peek_flags(4'b0110, "subi_flags");
    issue(mk(2'b11, 3'd1, 2'd2, 1'b0, 8'h02));
    drop(); wait_idle();
    peek(2'd2, 8'h00, "cmp_r2");
    peek_flags(4'b0110, "cmp_flags");
    @(negedge clk); chk("cmp_wb_held", {8'd0, wb_data}, 16'h0000); step();

    // LDI r3,5C; XOR rr r3,r3; LDI r3,77 (flags must survive the LDI)
    issue(mk(2'b10, 3'd0, 2'd3, 1'b0, 8'h5C));
    issue(mk(2'b00, 3'd4, 2'd3, 1'b0, 8'h03));
    drop(); wait_idle();
    peek(2'd3, 8'h00, "xor_r3");
    peek_flags(4'b0100, "xor_flags");
    issue(mk(2'b10, 3'd0, 2'd3, 1'b0, 8'h77));
    drop(); wait_idle();
    peek_flags(4'b0100, "ldi_keeps_flags");
    peek(2'd3, 8'h77, "ldi_r3");

`ifdef ALU_COND_EXEC_EN
    // Z=1: conditional ADD ri r1,1 is squashed.
    issue(mk(2'b01, 3'd0, 2'd1, 1'b1, 8'h01));
    drop(); wait_idle();
    peek(2'd1, 8'hA2, "cond_skip_r1");
    peek_flags(4'b0100, "cond_skip_flags");
    issue(mk(2'b10, 3'd0, 2'd0, 1'b0, 8'h01));
    issue(mk(2'b01, 3'd0, 2'd0, 1'b0, 8'h00));
    issue(mk(2'b01, 3'd0, 2'd1, 1'b1, 8'h01));
    drop(); wait_idle();
    peek(2'd1, 8'hA3, "cond_exec_r1");
`endif

    // Valid held through busy cycles: one accept every three cycles.
    prev_cyc = 0;
    for (int i = 0; i < 6; i++) begin
      issue(mk(2'(i % 4), 3'(i), 2'(i), 1'b0, 8'(8'h31 * i)));
      if (i > 0) chk("accept_gap", 16'(m_acc_cyc - prev_cyc), 16'd3);
      prev_cyc = m_acc_cyc;
    end
    drop(); wait_idle();

    // Random traffic with idle gaps and occasional resets.
    for (int k = 0; k < 200; k++) begin
      issue(16'($urandom));
      if ($urandom_range(0, 2) == 0) begin
        drop();
        repeat ($urandom_range(0, 4)) begin
          bus.insn = 16'($urandom); dbg_sel = 2'($urandom); step();
        end
      end
      if ($urandom_range(0, 39) == 0) begin
        rst = 1'b1;
        repeat ($urandom_range(1, 2)) step();
        rst = 1'b0;
      end
    end
    drop(); wait_idle();
    for (int i = 0; i < 4; i++) begin
      dbg_sel = 2'(i); step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
